// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester, RAM and status signals of the two-port RAM arbiter.
//   slave  modport - the arbiter: consumes req/we/addr/wdata and ram_dout,
//                    drives ack/rdata, ram_addr/ram_din/ram_we, busy, owner.
//   master modport - the environment (requesters plus RAM).
interface ram_arbiter_if;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   // requester 0
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;

   // requester 1
   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;

   // RAM side
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_we;
   logic [DATA_W-1:0] ram_dout;

   // status
   logic              busy;
   logic              owner;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  ram_dout,
      output ack0, rdata0, ack1, rdata1,
      output ram_addr, ram_din, ram_we,
      output busy, owner
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output ram_dout,
      input  ack0, rdata0, ack1, rdata1,
      input  ram_addr, ram_din, ram_we,
      input  busy, owner
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two requesters.
// Each grant runs IDLE -> SERVE -> RESP; the RAM is driven during SERVE, the
// owner's ack pulses during RESP and read data is captured at the SERVE->RESP edge.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - ram_arbiter_if.slave (requester handshakes, RAM port, busy/owner)
// Build option:
//   RAM_ARB_FIXED_PRIO_EN - when defined, simultaneous requests always go to
//                           requester 0; otherwise ties alternate (round-robin).
module ram_arbiter (
   input  logic           clk,
   input  logic           rst_n,
   ram_arbiter_if.slave   bus
);
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            state;
   logic              lat_we;
   logic              owner_q;
   logic              busy_q;
   logic              ack0_q;
   logic              ack1_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_din_q;
   logic              ram_we_q;

   logic              any_req_c;
   logic              grant_c;
   req_t              win_c;

   // Winner selection for the next IDLE->SERVE edge.
   always_comb begin
      any_req_c = bus.req0 | bus.req1;
      grant_c   = owner_q;
      if (bus.req0 && bus.req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         grant_c = 1'b0;
`else
         grant_c = ~owner_q;
`endif
      end else if (bus.req0) begin
         grant_c = 1'b0;
      end else if (bus.req1) begin
         grant_c = 1'b1;
      end
   end

   // Winner's request payload.
   always_comb begin
      if (grant_c) begin
         win_c = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
      end else begin
         win_c = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
      end
   end

   // FSM with registered outputs; ram_addr/ram_din double as the latched request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         lat_we     <= 1'b0;
         owner_q    <= 1'b1;
         busy_q     <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         ram_we_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req_c) begin
                  state      <= SERVE;
                  busy_q     <= 1'b1;
                  owner_q    <= grant_c;
                  lat_we     <= win_c.we;
                  ram_addr_q <= win_c.addr;
                  ram_din_q  <= win_c.wdata;
                  ram_we_q   <= win_c.we;
               end
            end
            SERVE: begin
               state    <= RESP;
               ram_we_q <= 1'b0;
               if (owner_q) begin
                  ack1_q <= 1'b1;
               end else begin
                  ack0_q <= 1'b1;
               end
               // ram_dout is combinational on ram_addr, valid during SERVE.
               if (!lat_we) begin
                  if (owner_q) begin
                     rdata1_q <= bus.ram_dout;
                  end else begin
                     rdata0_q <= bus.ram_dout;
                  end
               end
            end
            RESP: begin
               state  <= IDLE;
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               ack0_q   <= 1'b0;
               ack1_q   <= 1'b0;
               busy_q   <= 1'b0;
               ram_we_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack0     = ack0_q;
   assign bus.ack1     = ack1_q;
   assign bus.rdata0   = rdata0_q;
   assign bus.rdata1   = rdata1_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_din  = ram_din_q;
   assign bus.ram_we   = ram_we_q;
   assign bus.busy     = busy_q;
   assign bus.owner    = owner_q;

endmodule
